// File: rtl/riscv_rf_pkg.sv
// rtl/riscv_rf_pkg.sv - shared defaults, x0 constant and address-width helper for the register file
package riscv_rf_pkg;

    localparam int RF_DEF_XLEN = 32;
    localparam int RF_DEF_NREG = 32;
    localparam int RF_DEF_NRD  = 2;

    // Architectural zero register: never written, never busy.
    localparam int RF_X0_ADDR  = 0;

    // Address width that never collapses to zero bits for tiny register counts.
    function automatic int rf_addr_width(input int nreg);
        return (nreg <= 2) ? 1 : $clog2(nreg);
    endfunction

endpackage

// File: rtl/riscv_rf_scoreboard.sv
// rtl/riscv_rf_scoreboard.sv - per-register pending bits with issue/clear/flush and registered busy count
module riscv_rf_scoreboard
    import riscv_rf_pkg::*;
#(
    parameter int NREG = RF_DEF_NREG,
    parameter int AW   = rf_addr_width(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic            iss_en,
    input  logic [AW-1:0]   iss_addr,
    input  logic            flush,
    output logic [NREG-1:0] sb,
    output logic [AW:0]     busy_cnt
);

    localparam int CW = AW + 1;

    logic [NREG-1:0] sb_q;
    logic [NREG-1:0] sb_d;
    logic [CW-1:0]   cnt_q;
    logic [CW-1:0]   cnt_d;

    logic wr_hit;
    logic iss_hit;
    logic same_addr;
    logic issued_new;
    logic cleared;

    // Next pending vector and count; issue is applied after the writeback clear so it wins on the same register.
    always_comb begin
        wr_hit     = wr_en  && (wr_addr  != AW'(RF_X0_ADDR));
        iss_hit    = iss_en && (iss_addr != AW'(RF_X0_ADDR));
        same_addr  = (wr_addr == iss_addr);
        issued_new = iss_hit && !sb_q[iss_addr];
        cleared    = wr_hit && sb_q[wr_addr] && !(iss_hit && same_addr);
        sb_d       = sb_q;
        cnt_d      = cnt_q;
        if (flush) begin
            sb_d  = '0;
            cnt_d = '0;
        end else begin
            if (wr_hit) begin
                sb_d[wr_addr] = 1'b0;
            end
            if (iss_hit) begin
                sb_d[iss_addr] = 1'b1;
            end
            cnt_d = cnt_q + CW'(issued_new) - CW'(cleared);
        end
    end

    // Pending vector and count registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sb_q  <= '0;
            cnt_q <= '0;
        end else begin
            sb_q  <= sb_d;
            cnt_q <= cnt_d;
        end
    end

    assign sb       = sb_q;
    assign busy_cnt = cnt_q;

endmodule

// File: rtl/riscv_regfile_sb.sv
// rtl/riscv_regfile_sb.sv - multi-port integer register file with scoreboard; optional forwarding via RF_BYPASS_EN
module riscv_regfile_sb
    import riscv_rf_pkg::*;
#(
    parameter int XLEN = RF_DEF_XLEN,
    parameter int NREG = RF_DEF_NREG,
    parameter int NRD  = RF_DEF_NRD,
    parameter int AW   = rf_addr_width(NREG)
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic [NRD*AW-1:0]   rd_addr,
    output logic [NRD*XLEN-1:0] rd_data,
    output logic [NRD-1:0]      rd_busy,
    input  logic                wr_en,
    input  logic [AW-1:0]       wr_addr,
    input  logic [XLEN-1:0]     wr_data,
    input  logic                iss_en,
    input  logic [AW-1:0]       iss_addr,
    input  logic                flush,
    output logic [AW:0]         busy_cnt
);

    logic [XLEN-1:0] rf_q [NREG];
    logic [NREG-1:0] sb;
    logic            wr_hit;

    assign wr_hit = wr_en && (wr_addr != AW'(RF_X0_ADDR));

    riscv_rf_scoreboard #(
        .NREG (NREG),
        .AW   (AW)
    ) u_scoreboard (
        .clk      (clk),
        .rst_n    (rst_n),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .sb       (sb),
        .busy_cnt (busy_cnt)
    );

    // Register array: cleared on reset, one write port from writeback; x0 is never written.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREG; i++) begin
                rf_q[i] <= '0;
            end
        end else if (wr_hit) begin
            rf_q[wr_addr] <= wr_data;
        end
    end

`ifdef RF_BYPASS_EN
    logic iss_hit;
    assign iss_hit = iss_en && (iss_addr != AW'(RF_X0_ADDR));

    // Read muxes with writeback forwarding; a same-cycle issue to the forwarded register keeps it busy.
    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            if (a != AW'(RF_X0_ADDR)) begin
                rd_data[k*XLEN +: XLEN] = rf_q[a];
                rd_busy[k]              = sb[a];
                if (wr_hit && (a == wr_addr)) begin
                    rd_data[k*XLEN +: XLEN] = wr_data;
                    rd_busy[k]              = iss_hit && (iss_addr == a);
                end
            end
        end
    end
`else
    // Read muxes from registered state only; x0 reads as zero and never busy.
    always_comb begin
        logic [AW-1:0] a;
        a       = '0;
        rd_data = '0;
        rd_busy = '0;
        for (int k = 0; k < NRD; k++) begin
            a = rd_addr[k*AW +: AW];
            if (a != AW'(RF_X0_ADDR)) begin
                rd_data[k*XLEN +: XLEN] = rf_q[a];
                rd_busy[k]              = sb[a];
            end
        end
    end
`endif

endmodule

// File: tb/tb_riscv_regfile_sb.sv
// tb/tb_riscv_regfile_sb.sv - directed plus randomized self-checking bench against an array-based reference model
module tb_riscv_regfile_sb;

    localparam int XLEN = 32;
    localparam int NREG = 32;
    localparam int NRD  = 2;
    localparam int AW   = 5;

    logic                clk = 1'b0;
    logic                rst_n;
    logic [NRD*AW-1:0]   rd_addr;
    logic [NRD*XLEN-1:0] rd_data;
    logic [NRD-1:0]      rd_busy;
    logic                wr_en;
    logic [AW-1:0]       wr_addr;
    logic [XLEN-1:0]     wr_data;
    logic                iss_en;
    logic [AW-1:0]       iss_addr;
    logic                flush;
    logic [AW:0]         busy_cnt;

    int vectors     = 0;
    int miscompares = 0;

    logic [XLEN-1:0] m_rf   [NREG];
    bit              m_busy [NREG];

    riscv_regfile_sb #(
        .XLEN (XLEN),
        .NREG (NREG),
        .NRD  (NRD)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .rd_addr  (rd_addr),
        .rd_data  (rd_data),
        .rd_busy  (rd_busy),
        .wr_en    (wr_en),
        .wr_addr  (wr_addr),
        .wr_data  (wr_data),
        .iss_en   (iss_en),
        .iss_addr (iss_addr),
        .flush    (flush),
        .busy_cnt (busy_cnt)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish (observed running, expected done)");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        vectors++;
        assert (obs === expv) else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
        end
    endtask

    function automatic int model_count();
        int n = 0;
        for (int i = 0; i < NREG; i++) n += int'(m_busy[i]);
        return n;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NREG; i++) begin
            m_rf[i]   = '0;
            m_busy[i] = 1'b0;
        end
    endtask

    // Compare both read ports and the count against the model for the currently driven inputs.
    task automatic check_ports();
        for (int p = 0; p < NRD; p++) begin
            logic [AW-1:0]   a;
            logic [XLEN-1:0] ed;
            logic            eb;
            a  = rd_addr[p*AW +: AW];
            ed = (a == 0) ? '0 : m_rf[a];
            eb = (a == 0) ? 1'b0 : m_busy[a];
`ifdef RF_BYPASS_EN
            if (wr_en && wr_addr != 0 && a == wr_addr) begin
                ed = wr_data;
                eb = iss_en && (iss_addr == a);
            end
`endif
            check($sformatf("rd_data[%0d] x%0d", p, a), rd_data[p*XLEN +: XLEN], ed);
            check($sformatf("rd_busy[%0d] x%0d", p, a), {31'b0, rd_busy[p]}, {31'b0, eb});
        end
        check("busy_cnt", {26'b0, busy_cnt}, model_count());
    endtask

    // One clock: apply inputs at the falling edge, check combinational view, clock, update model, drop strobes.
    task automatic drive(input bit we, input logic [AW-1:0] wa, input logic [XLEN-1:0] wd,
                         input bit ie, input logic [AW-1:0] ia, input bit fl,
                         input logic [AW-1:0] r0, input logic [AW-1:0] r1);
        wr_en    = we;
        wr_addr  = wa;
        wr_data  = wd;
        iss_en   = ie;
        iss_addr = ia;
        flush    = fl;
        rd_addr  = {r1, r0};
        #1;
        check_ports();
        @(posedge clk);
        if (we && wa != 0) begin
            m_rf[wa]   = wd;
            m_busy[wa] = 1'b0;
        end
        if (fl) begin
            for (int i = 0; i < NREG; i++) m_busy[i] = 1'b0;
        end else if (ie && ia != 0) begin
            m_busy[ia] = 1'b1;
        end
        @(negedge clk);
        wr_en  = 1'b0;
        iss_en = 1'b0;
        flush  = 1'b0;
        #1;
    endtask

    initial begin
        rst_n    = 1'b0;
        wr_en    = 1'b0;
        wr_addr  = '0;
        wr_data  = '0;
        iss_en   = 1'b0;
        iss_addr = '0;
        flush    = 1'b0;
        rd_addr  = '0;
        model_reset();

        // Reset state on every address, both ports.
        @(negedge clk);
        @(negedge clk);
        for (int a = 0; a < NREG; a++) begin
            rd_addr = {AW'(a), AW'(a)};
            #1;
            check("reset rd_data0", rd_data[31:0], 32'h0);
            check("reset rd_data1", rd_data[63:32], 32'h0);
            check("reset rd_busy", {30'b0, rd_busy}, 32'h0);
        end
        check("reset busy_cnt", {26'b0, busy_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Write x5, attempt write x0.
        drive(1, 5, 32'hDEADBEEF, 0, 0, 0, 5, 5);
        drive(1, 0, 32'h00001234, 0, 0, 0, 0, 5);
        drive(0, 0, 0, 0, 0, 0, 0, 5);
        check("x0 reads zero", rd_data[31:0], 32'h0);
        check("x5 port1", rd_data[63:32], 32'hDEADBEEF);

        // Issue / writeback counting.
        drive(0, 0, 0, 1, 7, 0, 7, 9);
        check("cnt after iss x7", {26'b0, busy_cnt}, 32'd1);
        drive(0, 0, 0, 1, 9, 0, 7, 9);
        check("cnt after iss x9", {26'b0, busy_cnt}, 32'd2);
        drive(1, 7, 32'h77, 0, 0, 0, 7, 9);
        check("x7 busy after wr", {31'b0, rd_busy[0]}, 32'd0);
        check("cnt after wr x7", {26'b0, busy_cnt}, 32'd1);
        drive(0, 0, 0, 1, 9, 0, 7, 9);
        check("cnt after reissue x9", {26'b0, busy_cnt}, 32'd1);

        // Same-cycle issue and writeback to x3: data lands, issue wins.
        drive(1, 3, 32'hA5, 1, 3, 0, 3, 9);
        check("x3 data", rd_data[31:0], 32'hA5);
        check("x3 busy", {31'b0, rd_busy[0]}, 32'd1);
        check("cnt after x3", {26'b0, busy_cnt}, 32'd2);

        // Issue x1..x4 then flush with a concurrent issue of x6.
        for (int r = 1; r <= 4; r++) drive(0, 0, 0, 1, AW'(r), 0, AW'(r), 6);
        drive(0, 0, 0, 1, 6, 1, 1, 6);
        check("cnt after flush", {26'b0, busy_cnt}, 32'd0);
        check("busy after flush", {30'b0, rd_busy}, 32'd0);

        // Same-cycle write/read of x10 (forwarded only with bypass).
        drive(1, 10, 32'h55AA, 0, 0, 0, 10, 5);
        drive(0, 0, 0, 1, 5, 0, 10, 5);

        // Asynchronous reset mid-cycle.
        rd_addr = {AW'(5), AW'(10)};
        #3;
        rst_n = 1'b0;
        #1;
        model_reset();
        check("midreset x10", rd_data[31:0], 32'h0);
        check("midreset x5", rd_data[63:32], 32'h0);
        check("midreset busy", {30'b0, rd_busy}, 32'h0);
        check("midreset cnt", {26'b0, busy_cnt}, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // Randomized traffic with address collisions biased in.
        for (int n = 0; n < 400; n++) begin
            bit              we, ie, fl;
            logic [AW-1:0]   wa, ia, r0, r1;
            logic [XLEN-1:0] wd;
            we = 1'($urandom_range(0, 1));
            ie = 1'($urandom_range(0, 1));
            fl = ($urandom_range(0, 15) == 0);
            wa = AW'($urandom_range(0, 7));
            ia = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
            wd = $urandom;
            r0 = ($urandom_range(0, 3) == 0) ? wa : AW'($urandom_range(0, 7));
            r1 = AW'($urandom_range(0, NREG - 1));
            drive(we, wa, wd, ie, ia, fl, r0, r1);
        end
        drive(0, 0, 0, 0, 0, 0, 1, 2);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
